// File: rtl/mem_access_unit.sv
// Load/store access unit in front of data port B of the instruction/data block RAM.
// Takes one request at a time, drives address, lane-replicated write data and byte enables, and returns aligned load data.
module mem_access_unit #(
  parameter int MEM_AW = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_data_addr,
  output logic [31:0] mem_data_input,
  output logic [3:0]  mem_data_wea,
  input  logic [31:0] mem_data_output,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers where resp_valid && resp_ready. Once valid is raised, the
  // payload is held stable until the transfer edge. req_ready is high only in IDLE.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  offset_q, offset_d;
  logic        we_q, we_d;

  logic        req_ready_d;
  logic        resp_valid_d;
  logic [31:0] resp_rdata_d;
  logic        resp_err_d;
  logic [31:0] mem_addr_d;
  logic [31:0] mem_input_d;
  logic [3:0]  mem_wea_d;

  logic        accept;
  logic        req_bad;
  logic [31:0] wdata_rep;
  logic [3:0]  wea_pat;
  logic [31:0] rd_shifted;
  logic [31:0] rd_fmt;

  assign dbg_state = state_q;
  assign accept    = req_valid & req_ready;

  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'b11) req_bad = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_bad = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_bad = 1'b1;
    if ((req_addr >> MEM_AW) != 32'd0) req_bad = 1'b1;
  end

  // Replicating the store data into every lane lets the byte enable alone pick the target bytes.
  always_comb begin
    wdata_rep = req_wdata;
    wea_pat   = 4'b1111;
    case (req_size)
      2'b00: begin
        wdata_rep = {4{req_wdata[7:0]}};
        wea_pat   = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wdata_rep = {2{req_wdata[15:0]}};
        wea_pat   = 4'b0011 << req_addr[1:0];
      end
      default: begin
        wdata_rep = req_wdata;
        wea_pat   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    rd_shifted = mem_data_output >> {offset_q, 3'b000};
    rd_fmt     = rd_shifted;
    case (size_q)
      2'b00:   rd_fmt = signed_q ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                                 : {24'h000000, rd_shifted[7:0]};
      2'b01:   rd_fmt = signed_q ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                                 : {16'h0000, rd_shifted[15:0]};
      default: rd_fmt = rd_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    signed_d     = signed_q;
    offset_d     = offset_q;
    we_d         = we_q;
    req_ready_d  = req_ready;
    resp_valid_d = resp_valid;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    mem_addr_d   = mem_data_addr;
    mem_input_d  = mem_data_input;
    mem_wea_d    = 4'b0000;

    case (state_q)
      IDLE: begin
        if (accept) begin
          size_d       = req_size;
          signed_d     = req_signed;
          offset_d     = req_addr[1:0];
          we_d         = req_we;
          req_ready_d  = 1'b0;
          resp_rdata_d = 32'h0;
          if (req_bad) begin
            // Rejected requests skip memory entirely so nothing out of range is ever presented.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ACCESS;
            resp_err_d = 1'b0;
            mem_addr_d = req_addr;
            if (req_we) begin
              mem_input_d = wdata_rep;
              mem_wea_d   = wea_pat;
            end
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The RAM registered the address at the end of ACCESS, so its output is valid here.
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = rd_fmt;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      size_q         <= 2'b00;
      signed_q       <= 1'b0;
      offset_q       <= 2'b00;
      we_q           <= 1'b0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'h0;
      resp_err       <= 1'b0;
      mem_data_addr  <= 32'h0;
      mem_data_input <= 32'h0;
      mem_data_wea   <= 4'b0000;
    end else begin
      state_q        <= state_d;
      size_q         <= size_d;
      signed_q       <= signed_d;
      offset_q       <= offset_d;
      we_q           <= we_d;
      req_ready      <= req_ready_d;
      resp_valid     <= resp_valid_d;
      resp_rdata     <= resp_rdata_d;
      resp_err       <= resp_err_d;
      mem_data_addr  <= mem_addr_d;
      mem_data_input <= mem_input_d;
      mem_data_wea   <= mem_wea_d;
    end
  end

  a_wea_only_in_access: assert property (@(posedge clk) disable iff (!rst)
    (mem_data_wea != 4'b0000) |-> (state_q == ACCESS));

  a_ready_only_in_idle: assert property (@(posedge clk) disable iff (!rst)
    req_ready == (state_q == IDLE));

  a_resp_held: assert property (@(posedge clk) disable iff (!rst)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rdata) && $stable(resp_err)));

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a block-RAM model on port B, a byte-level reference memory,
// directed vectors, backpressure and reset corner cases, then randomized traffic.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_data_addr;
  logic [31:0] mem_data_input;
  logic [3:0]  mem_data_wea;
  logic [31:0] mem_data_output;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.MEM_AW(18)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_data_addr(mem_data_addr), .mem_data_input(mem_data_input), .mem_data_wea(mem_data_wea),
    .mem_data_output(mem_data_output), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Block RAM on port B: byte-enabled write, one-cycle registered read.
  logic [31:0] bram [0:65535] = '{default: 32'h0};
  initial mem_data_output = 32'h0;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_data_wea[i]) bram[mem_data_addr[17:2]][8*i +: 8] <= mem_data_input[8*i +: 8];
    mem_data_output <= bram[mem_data_addr[17:2]];
  end

  // ---------------- reference model (byte addressed) ----------------
  logic [7:0] ref_bytes [0:262143] = '{default: 8'h00};

  function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = 1 << size;
    return (size == 2'd3) || ((addr % 32'(n)) != 0) || (addr >= 32'h0004_0000);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sg, input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[18'(addr + 32'(i))]) << (8*i));
    if (n < 4 && sg && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 1 << size;
    for (int i = 0; i < n; i++) ref_bytes[18'(addr + 32'(i))] = 8'(wdata >> (8*i));
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] size, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic [3:0] wea_or, output int wea_cyc, output logic [31:0] din);
    @(negedge clk);
    check("req_ready_before_request", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0; wea_or = 4'h0; wea_cyc = 0; din = 32'h0;
    for (int n = 1; n <= 12; n++) begin
      if (mem_data_wea != 4'h0) begin
        wea_or = wea_or | mem_data_wea;
        wea_cyc++;
        din = mem_data_input;
      end
      if (resp_valid) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    rdata = resp_rdata;
    err   = resp_err;
    if (lat == 0) begin
      check("response_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
      check("release_valid_ready_wea", {26'h0, resp_valid, req_ready, mem_data_wea}, {26'h0, 2'b01, 4'h0});
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  wea;
    logic [31:0] din;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic err,
                              input logic [31:0] rdata, input logic [3:0] wea, input logic [31:0] din);
    vec_t v;
    v.we = we; v.size = size; v.sg = sg; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.wea = wea; v.din = din;
    return v;
  endfunction

  logic [31:0] r_rdata, r_din, exp_v, exp_din, din_mask, held;
  logic        r_err;
  logic [3:0]  r_wea, exp_wea;
  int          r_lat, r_wcyc, exp_lat, seen;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;

    vecs.push_back(mk(1, 2'd2, 0, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0,         4'hF, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 2'd0, 1, 32'h0000_1003, 32'h0,         0, 32'hFFFF_FFDE, 4'h0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 32'h0000_1003, 32'h0,         0, 32'h0000_00DE, 4'h0, 32'h0));
    vecs.push_back(mk(1, 2'd1, 0, 32'h0000_1002, 32'hAAAA_1234, 0, 32'h0,         4'hC, 32'h1234_1234));
    vecs.push_back(mk(0, 2'd1, 0, 32'h0000_1002, 32'h0,         0, 32'h0000_1234, 4'h0, 32'h0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h0000_1000, 32'h0,         0, 32'h1234_BEEF, 4'h0, 32'h0));
    vecs.push_back(mk(0, 2'd1, 1, 32'h0000_1000, 32'h0,         0, 32'hFFFF_BEEF, 4'h0, 32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 32'h0000_1001, 32'h0000_0055, 0, 32'h0,         4'h2, 32'h5555_5555));
    vecs.push_back(mk(0, 2'd2, 0, 32'h0000_1000, 32'h0,         0, 32'h1234_55EF, 4'h0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 1, 32'h0000_1001, 32'h0,         0, 32'h0000_0055, 4'h0, 32'h0));
    vecs.push_back(mk(0, 2'd1, 0, 32'h0000_1001, 32'h0,         1, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1, 2'd2, 0, 32'h0000_1002, 32'hFFFF_FFFF, 1, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(0, 2'd3, 0, 32'h0000_1000, 32'h0,         1, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h0004_0000, 32'h0,         1, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 32'h8000_0000, 32'h0000_0077, 1, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h0000_1000, 32'h0,         0, 32'h1234_55EF, 4'h0, 32'h0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h0000_0000, 32'h0,         0, 32'h0000_0000, 4'h0, 32'h0));

    // Reset state, held and after release.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid_err", {30'h0, resp_valid, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", mem_data_addr, 32'h0);
    check("rst_mem_input", mem_data_input, 32'h0);
    check("rst_wea", 32'(mem_data_wea), 32'h0);
    check("rst_state_idle", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {29'h0, req_ready, resp_valid, mem_data_wea != 4'h0}, {29'h0, 3'b100});

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].sg, vecs[i].addr, vecs[i].wdata,
             r_rdata, r_err, r_lat, r_wea, r_wcyc, r_din);
      exp_lat = vecs[i].err ? 1 : (vecs[i].we ? 2 : 3);
      check($sformatf("vec%0d_err", i), 32'(r_err), 32'(vecs[i].err));
      check($sformatf("vec%0d_rdata", i), r_rdata, vecs[i].rdata);
      check($sformatf("vec%0d_latency", i), 32'(r_lat), 32'(exp_lat));
      check($sformatf("vec%0d_wea", i), 32'(r_wea), 32'(vecs[i].wea));
      check($sformatf("vec%0d_wea_cycles", i), 32'(r_wcyc), (vecs[i].we && !vecs[i].err) ? 32'd1 : 32'd0);
      if (vecs[i].we && !vecs[i].err) begin
        check($sformatf("vec%0d_wdata_bus", i), r_din, vecs[i].din);
        ref_store(vecs[i].size, vecs[i].addr, vecs[i].wdata);
      end
    end

    // Backpressure: response held for 5 cycles, a competing request must not get in.
    exp_v = ref_load(2'd2, 1'b0, 32'h1000);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h1000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 10 && !resp_valid; n++) begin
      @(posedge clk);
      #1;
    end
    check("bp_resp_valid_arrives", 32'(resp_valid), 32'd1);
    held = resp_rdata;
    check("bp_rdata", held, exp_v);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h1000; req_wdata = 32'h0BAD_F00D;
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_valid_ready_wea", c), {26'h0, resp_valid, req_ready, mem_data_wea}, {26'h0, 2'b10, 4'h0});
      check($sformatf("bp_hold%0d_rdata", c), resp_rdata, exp_v);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {29'h0, resp_valid, req_ready, dbg_state == 2'd0}, {29'h0, 3'b011});
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, r_rdata, r_err, r_lat, r_wea, r_wcyc, r_din);
    check("bp_store_not_accepted", r_rdata, exp_v);

    // Reset asserted while a load sits in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h1000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rw_in_wait_state", 32'(dbg_state), 32'd2);
    #1;
    rst = 1'b0;
    #1;
    check("rw_state_idle", 32'(dbg_state), 32'd0);
    check("rw_ready_valid_err", {29'h0, req_ready, resp_valid, resp_err}, {29'h0, 3'b100});
    check("rw_rdata", resp_rdata, 32'h0);
    check("rw_mem_addr", mem_data_addr, 32'h0);
    check("rw_mem_input_wea", {mem_data_input[27:0], mem_data_wea}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 2'd0, 1'b1, 32'h1000, 32'h0, r_rdata, r_err, r_lat, r_wea, r_wcyc, r_din);
    check("rw_next_rdata", r_rdata, ref_load(2'd0, 1'b1, 32'h1000));
    check("rw_next_latency", 32'(r_lat), 32'd3);

    // Randomized traffic against the byte-level reference.
    for (int t = 0; t < 300; t++) begin
      logic        we, sg, e;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
      we    = 1'($urandom_range(0, 1));
      sg    = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr  = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0004_0000) : (32'h2000 + $urandom_range(0, 63));
      wdata = $urandom;
      e = ref_err(size, addr);
      exp_q.push_back((e || we) ? 32'h0 : ref_load(size, sg, addr));
      do_req(we, size, sg, addr, wdata, r_rdata, r_err, r_lat, r_wea, r_wcyc, r_din);
      check($sformatf("rnd%0d_err", t), 32'(r_err), 32'(e));
      check($sformatf("rnd%0d_rdata", t), r_rdata, exp_q.pop_front());
      check($sformatf("rnd%0d_latency", t), 32'(r_lat), e ? 32'd1 : (we ? 32'd2 : 32'd3));
      check($sformatf("rnd%0d_wea_cycles", t), 32'(r_wcyc), (we && !e) ? 32'd1 : 32'd0);
      if (we && !e) begin
        exp_wea = 4'h0; exp_din = 32'h0; din_mask = 32'h0;
        for (int i = 0; i < (1 << size); i++) begin
          exp_wea[addr[1:0] + 2'(i)] = 1'b1;
          exp_din[8*(addr[1:0] + 2'(i)) +: 8] = 8'(wdata >> (8*i));
          din_mask[8*(addr[1:0] + 2'(i)) +: 8] = 8'hFF;
        end
        check($sformatf("rnd%0d_wea", t), 32'(r_wea), 32'(exp_wea));
        check($sformatf("rnd%0d_wdata_lanes", t), r_din & din_mask, exp_din);
        ref_store(size, addr, wdata);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
